eth_rx_frame_buffer: RTL and testbench

Store-and-forward receive frame buffer between the Ethernet MAC RX AXI-Stream (64-bit, `eth0_rx_axis_*` of `ethernet_u280`) and the RISC-V SoC Ethernet RX port (`eth_rx_axis_*` of `riscv`).
- The MAC cannot be back-pressured; this block always accepts beats.
- It drops frames flagged bad by `tuser` (FCS/length error) and frames that overflow the buffer.
- It forwards only complete, good frames under full `tready` flow control.

---
 rtl/eth_pkg.sv | 26 ++
 rtl/eth_frame_ram.sv | 32 +++
 rtl/eth_rx_frame_buffer.sv | 174 +++++++++++++++++
 tb/tb_eth_rx_frame_buffer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared types for the Ethernet RX frame buffer: beat layout, write-FSM states
// and a saturating counter helper.
package eth_pkg;

    localparam int ETH_DATA_W = 64;
    localparam int ETH_KEEP_W = 8;

    typedef struct packed {
        logic                  tlast;
        logic [ETH_KEEP_W-1:0] tkeep;
        logic [ETH_DATA_W-1:0] tdata;
    } eth_beat_t;

    localparam int ETH_BEAT_W = $bits(eth_beat_t);

    typedef enum logic [1:0] {
        SYNC,
        PASS,
        DROP
    } rxbuf_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/eth_frame_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port.
// The read register holds its value while re_i is low.
module eth_frame_ram
    import eth_pkg::*;
#(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [ETH_BEAT_W-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [ETH_BEAT_W-1:0] rdata_o
);

    logic [ETH_BEAT_W-1:0] mem_q [DEPTH];
    logic [ETH_BEAT_W-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/eth_rx_frame_buffer.sv
// Store-and-forward RX frame buffer: accepts MAC beats unconditionally, drops bad
// or overflowing frames, and forwards only committed frames with full flow control.
module eth_rx_frame_buffer
    import eth_pkg::*;
#(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] frames_ok,
    output logic [15:0] drop_err,
    output logic [15:0] drop_ovf
);

    localparam int PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);

    rxbuf_state_t     state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] wr_commit_q, wr_commit_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             rd_busy_q, rd_busy_d;
    logic             out_valid_q, out_valid_d;
    eth_beat_t        out_beat_q, out_beat_d;
    logic [31:0]      frames_ok_q, frames_ok_d;
    logic [15:0]      drop_err_q, drop_err_d;
    logic [15:0]      drop_ovf_q, drop_ovf_d;
    logic             tready_q;

    logic             full;
    logic             ram_we;
    logic             rd_issue;
    logic             out_free;
    eth_beat_t        wr_beat;
    eth_beat_t        ram_rdata;

    assign full    = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
    assign wr_beat = '{tlast: s_axis_tlast, tkeep: s_axis_tkeep, tdata: s_axis_tdata};

    // Write side: a frame is only made visible to the reader when its good tlast
    // beat lands; any failure rewinds the speculative pointer to the last commit.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        frames_ok_d = frames_ok_q;
        drop_err_d  = drop_err_q;
        drop_ovf_d  = drop_ovf_q;
        ram_we      = 1'b0;
        if (s_axis_tvalid) begin
            case (state_q)
                SYNC: begin
                    if (s_axis_tlast) begin
                        state_d = PASS;
                    end
                end
                PASS: begin
                    if (!full) begin
                        if (!s_axis_tlast) begin
                            ram_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + ONE_P;
                        end else if (!s_axis_tuser) begin
                            ram_we      = 1'b1;
                            wr_ptr_d    = wr_ptr_q + ONE_P;
                            wr_commit_d = wr_ptr_q + ONE_P;
                            frames_ok_d = frames_ok_q + 32'd1;
                        end else begin
                            wr_ptr_d   = wr_commit_q;
                            drop_err_d = sat_inc16(drop_err_q);
                        end
                    end else begin
                        wr_ptr_d = wr_commit_q;
                        if (s_axis_tlast) begin
                            drop_ovf_d = sat_inc16(drop_ovf_q);
                        end else begin
                            state_d = DROP;
                        end
                    end
                end
                DROP: begin
                    if (s_axis_tlast) begin
                        drop_ovf_d = sat_inc16(drop_ovf_q);
                        state_d    = PASS;
                    end
                end
                default: state_d = SYNC;
            endcase
        end else if (state_q == SYNC) begin
            state_d = PASS;
        end
    end

    // Read side: the word in the RAM read register waits there until the output
    // register can take it, so a new read is only issued when that move happens.
    always_comb begin
        out_free    = !out_valid_q || m_axis_tready;
        rd_issue    = (rd_ptr_q != wr_commit_q) && out_free;
        rd_ptr_d    = rd_issue ? rd_ptr_q + ONE_P : rd_ptr_q;
        rd_busy_d   = rd_busy_q;
        out_valid_d = out_valid_q;
        out_beat_d  = out_beat_q;
        if (out_free) begin
            out_valid_d = rd_busy_q;
            if (rd_busy_q) begin
                out_beat_d = ram_rdata;
            end
            rd_busy_d = rd_issue;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= SYNC;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            rd_busy_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_beat_q  <= '0;
            frames_ok_q <= '0;
            drop_err_q  <= '0;
            drop_ovf_q  <= '0;
            tready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_busy_q   <= rd_busy_d;
            out_valid_q <= out_valid_d;
            out_beat_q  <= out_beat_d;
            frames_ok_q <= frames_ok_d;
            drop_err_q  <= drop_err_d;
            drop_ovf_q  <= drop_ovf_d;
            tready_q    <= 1'b1;
        end
    end

    eth_frame_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock   (clock),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (wr_beat),
        .re_i    (rd_issue),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (ram_rdata)
    );

    assign s_axis_tready = tready_q;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_beat_q.tdata;
    assign m_axis_tkeep  = out_beat_q.tkeep;
    assign m_axis_tlast  = out_beat_q.tlast;
    assign frames_ok     = frames_ok_q;
    assign drop_err      = drop_err_q;
    assign drop_ovf      = drop_ovf_q;

endmodule

// File: tb/tb_eth_rx_frame_buffer.sv
// Bench for eth_rx_frame_buffer: a default-depth instance and a 16-deep instance
// share the input bus; each has its own expected-beat queue and output monitor.
module tb_eth_rx_frame_buffer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tlast, s_tuser, s_tvalid, sel16;
    logic        s_tvalid_a, s_tvalid_b;
    logic        tready_a, tready_b;

    logic        a_sready, a_tvalid, a_tlast;
    logic [63:0] a_tdata;
    logic [7:0]  a_tkeep;
    logic [31:0] a_fok;
    logic [15:0] a_derr, a_dovf;

    logic        b_sready, b_tvalid, b_tlast;
    logic [63:0] b_tdata;
    logic [7:0]  b_tkeep;
    logic [31:0] b_fok;
    logic [15:0] b_derr, b_dovf;

    assign s_tvalid_a = s_tvalid & ~sel16;
    assign s_tvalid_b = s_tvalid & sel16;

    eth_rx_frame_buffer dut (
        .clock(clk), .resetn(resetn),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid_a), .s_axis_tready(a_sready),
        .m_axis_tdata(a_tdata), .m_axis_tkeep(a_tkeep), .m_axis_tlast(a_tlast),
        .m_axis_tvalid(a_tvalid), .m_axis_tready(tready_a),
        .frames_ok(a_fok), .drop_err(a_derr), .drop_ovf(a_dovf)
    );

    eth_rx_frame_buffer #(.DEPTH(16)) dut16 (
        .clock(clk), .resetn(resetn),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid_b), .s_axis_tready(b_sready),
        .m_axis_tdata(b_tdata), .m_axis_tkeep(b_tkeep), .m_axis_tlast(b_tlast),
        .m_axis_tvalid(b_tvalid), .m_axis_tready(tready_b),
        .frames_ok(b_fok), .drop_err(b_derr), .drop_ovf(b_dovf)
    );

    logic [72:0] q_a[$];
    logic [72:0] q_b[$];
    int          total = 0;
    int          bad   = 0;

    logic [72:0] prev_a, prev_b;
    logic        stall_a = 1'b0, stall_b = 1'b0;

    // Monitor for the default-depth instance: scoreboard pop plus hold-while-stalled.
    always @(negedge clk) begin
        logic [72:0] cur, exp;
        cur = {a_tlast, a_tkeep, a_tdata};
        if (stall_a) begin
            total++;
            if (!a_tvalid || cur !== prev_a) begin
                bad++;
                $display("FAIL a_stall_hold got=%b/%h required=1/%h", a_tvalid, cur, prev_a);
            end
        end
        if (resetn && a_tvalid && tready_a) begin
            total++;
            if (q_a.size() == 0) begin
                bad++;
                $display("FAIL a_unexpected_beat got=%h required=none", cur);
            end else begin
                exp = q_a.pop_front();
                if (cur !== exp) begin
                    bad++;
                    $display("FAIL a_beat got=%h required=%h", cur, exp);
                end
            end
        end
        stall_a = resetn && a_tvalid && !tready_a;
        prev_a  = cur;
    end

    always @(negedge clk) begin
        logic [72:0] cur, exp;
        cur = {b_tlast, b_tkeep, b_tdata};
        if (stall_b) begin
            total++;
            if (!b_tvalid || cur !== prev_b) begin
                bad++;
                $display("FAIL b_stall_hold got=%b/%h required=1/%h", b_tvalid, cur, prev_b);
            end
        end
        if (resetn && b_tvalid && tready_b) begin
            total++;
            if (q_b.size() == 0) begin
                bad++;
                $display("FAIL b_unexpected_beat got=%h required=none", cur);
            end else begin
                exp = q_b.pop_front();
                if (cur !== exp) begin
                    bad++;
                    $display("FAIL b_beat got=%h required=%h", cur, exp);
                end
            end
        end
        stall_b = resetn && b_tvalid && !tready_b;
        prev_b  = cur;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    // Drives one frame starting just after a rising edge; returns 1ns after the
    // edge that accepts tlast with tvalid already dropped.
    task automatic send_frame(input int fid, input int n, input logic [7:0] last_keep,
                              input logic bad_flag, input logic to_b, input logic keep_out);
        sel16 = to_b;
        for (int i = 0; i < n; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = {16'hBEEF, 16'(fid), 16'(i), 16'(fid * 37 + i * 5)};
            s_tkeep  = (i == n - 1) ? last_keep : 8'hFF;
            s_tlast  = (i == n - 1);
            s_tuser  = (i == n - 1) && bad_flag;
            if (keep_out) begin
                if (to_b) q_b.push_back({s_tlast, s_tkeep, s_tdata});
                else      q_a.push_back({s_tlast, s_tkeep, s_tdata});
            end
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        int c;
        c = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && c < max_cyc) begin
            @(posedge clk); #1;
            c++;
        end
        total++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout got=%0d/%0d required=0/0", q_a.size(), q_b.size());
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_a_tvalid"}, 64'(a_tvalid), 64'd0);
        chk({tag, "_a_tdata"},  a_tdata, 64'd0);
        chk({tag, "_a_tkeep"},  64'(a_tkeep), 64'd0);
        chk({tag, "_a_tlast"},  64'(a_tlast), 64'd0);
        chk({tag, "_a_sready"}, 64'(a_sready), 64'd0);
        chk({tag, "_a_cnt"},    {a_fok, a_derr, a_dovf}, 64'd0);
        chk({tag, "_b_cnt"},    {b_fok, b_derr, b_dovf}, 64'd0);
    endtask

    initial begin
        bit done;
        resetn   = 1'b0;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
        s_tdata  = '0;   s_tkeep = '0;   sel16 = 1'b0;
        tready_a = 1'b1; tready_b = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("rst0");
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("sready_after_reset", 64'(a_sready), 64'd1);

        // One 8-beat good frame; first beat two edges after the tlast edge.
        send_frame(1, 8, 8'h0F, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("latency_t1_tvalid", 64'(a_tvalid), 64'd0);
        @(posedge clk); #1;
        chk("latency_t2_tvalid", 64'(a_tvalid), 64'd1);
        chk("latency_t2_beat0", a_tdata, {16'hBEEF, 16'd1, 16'd0, 16'd37});
        drain(100);
        chk("t1_frames_ok", 64'(a_fok), 64'd1);

        // Good, bad (tuser), good.
        send_frame(2, 4, 8'hFF, 1'b0, 1'b0, 1'b1);
        send_frame(3, 4, 8'h03, 1'b1, 1'b0, 1'b0);
        send_frame(4, 3, 8'h7F, 1'b0, 1'b0, 1'b1);
        drain(100);
        chk("t2_frames_ok", 64'(a_fok), 64'd3);
        chk("t2_drop_err", 64'(a_derr), 64'd1);
        chk("t2_drop_ovf", 64'(a_dovf), 64'd0);

        // 16-deep instance: second 10-beat frame overflows while output stalls.
        tready_b = 1'b0;
        send_frame(10, 10, 8'h01, 1'b0, 1'b1, 1'b1);
        send_frame(11, 10, 8'h03, 1'b0, 1'b1, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("t3_b_frames_ok", 64'(b_fok), 64'd1);
        chk("t3_b_drop_ovf", 64'(b_dovf), 64'd1);
        chk("t3_b_drop_err", 64'(b_derr), 64'd0);
        tready_b = 1'b1;
        drain(100);
        send_frame(12, 2, 8'hFF, 1'b0, 1'b1, 1'b1);
        drain(100);
        chk("t3_b_frames_ok_after", 64'(b_fok), 64'd2);
        sel16 = 1'b0;

        // Reset released three beats before tlast of an in-progress frame.
        resetn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 64'hDEAD_0000_0000_0000 | 64'(i);
            s_tkeep  = 8'hFF;
            s_tlast  = (i == 7);
            s_tuser  = 1'b0;
            if (i == 5) resetn = 1'b1;
            @(posedge clk); #1;
            if (i == 2) chk_reset_state("rst1");
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t4_no_output", 64'(a_tvalid), 64'd0);
        chk("t4_frames_ok_zero", 64'(a_fok), 64'd0);
        send_frame(40, 5, 8'h1F, 1'b0, 1'b0, 1'b1);
        drain(100);
        chk("t4_frames_ok", 64'(a_fok), 64'd1);

        // Back-to-back 64-beat frames against a randomly stalling sink.
        done = 1'b0;
        fork
            begin
                for (int f = 0; f < 6; f++) begin
                    send_frame(50 + f, 64, 8'(8'hFF >> f), 1'b0, 1'b0, 1'b1);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    tready_a = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        for (int c = 0; c < 600 && q_a.size() != 0; c++) begin
            tready_a = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        tready_a = 1'b1;
        drain(200);
        chk("t5_frames_ok", 64'(a_fok), 64'd7);
        chk("t5_drop_err", 64'(a_derr), 64'd0);
        chk("t5_drop_ovf", 64'(a_dovf), 64'd0);
        chk("t5_idle", 64'(a_tvalid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
